// File: rtl/fifo_stream_reader_if.sv
// Stream side of fifo_stream_reader: valid/ready beat with data (and m_last when FIFO_RD_LAST_EN is defined).
// master = the reader producing beats, slave = the downstream consumer.
interface fifo_stream_reader_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
`ifdef FIFO_RD_LAST_EN
  logic                  m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);
`else
  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);
`endif
endinterface

// File: rtl/fifo_stream_reader.sv
// Read-side FIFO adapter: issues read_en, absorbs the 1-cycle read latency in a 3-entry skid, emits a valid/ready stream.
// Latency read_en->m_valid 2 cycles, 1 word/cycle sustained; optional m_last packet framing via `define FIFO_RD_LAST_EN.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int PKT_LEN    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_read_en,
  fifo_stream_reader_if.master  m,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic                  busy
);

  if (PKT_LEN < 1) begin : g_bad_pkt_len
    $error("fifo_stream_reader: PKT_LEN must be >= 1");
  end

  logic [DATA_WIDTH-1:0] buf_mem [0:2];
  logic [1:0]            wr_idx;
  logic [1:0]            rd_idx;
  logic [1:0]            occ;
  logic                  inflight;
  logic                  valid;
  logic                  pop;
  logic [2:0]            committed;

  function automatic logic [1:0] idx_next(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // A slot is reserved for every read still in flight, so the buffer cannot overflow
  // and m_ready never has to enter the read_en path.
  assign committed    = {1'b0, occ} + {2'b00, inflight};
  assign fifo_read_en = !reset && enable && !fifo_empty && (committed < 3'd3);

  assign valid     = (occ != 2'd0);
  assign pop       = valid && m.m_ready;
  assign m.m_valid = valid;
  assign m.m_data  = valid ? buf_mem[rd_idx] : '0;
  assign busy      = valid || inflight;

  always_ff @(posedge clk) begin
    if (reset) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      wr_idx   <= 2'd0;
      rd_idx   <= 2'd0;
      rd_count <= '0;
    end else begin
      inflight <= fifo_read_en;
      if (inflight) begin
        wr_idx <= idx_next(wr_idx);
      end
      if (pop) begin
        rd_idx   <= idx_next(rd_idx);
        rd_count <= rd_count + CNT_WIDTH'(1);
      end
      occ <= occ + {1'b0, inflight} - {1'b0, pop};
    end
  end

  // Storage carries no reset; a word only becomes visible once occ counts it.
  always_ff @(posedge clk) begin
    if (!reset && inflight) begin
      buf_mem[wr_idx] <= fifo_dout;
    end
  end

`ifdef FIFO_RD_LAST_EN
  localparam int PW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [PW-1:0] PKT_MAX = PW'(PKT_LEN - 1);

  logic [PW-1:0] pkt_cnt;
  logic          last;

  assign last     = valid && (pkt_cnt == PKT_MAX);
  assign m.m_last = last;

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_cnt <= '0;
    end else if (pop) begin
      pkt_cnt <= last ? '0 : pkt_cnt + PW'(1);
    end
  end
`endif

endmodule
